// File: rtl/alu16.sv
// alu16: registered 16-bit execute-stage ALU.
// Combinational datapath computes every operation from the sampled a/b/ctrl,
// and the selected result plus flags are captured on the rising clock edge.
// Multiply and divide also load the R15 side register; every other op leaves it untouched.

module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] R15,
    output logic             r15_we,
    output logic             zero,
    output logic             ovf
);

    localparam int DW  = 2 * WIDTH;
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Registered state
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] r15_q, r15_d;
    logic             r15_we_q, r15_we_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    // Datapath intermediates
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        sum;
    logic [WIDTH-1:0]        diff;
    logic signed [DW-1:0]    a_ext;
    logic signed [DW-1:0]    b_ext;
    logic signed [DW-1:0]    prod;
    logic signed [WIDTH-1:0] quot;
    logic signed [WIDTH-1:0] rem;
    logic                    div_by_zero;
    logic                    div_ovf;
    logic [DW-1:0]           rot_src;
    logic [DW-1:0]           rol_full;
    logic [DW-1:0]           ror_full;

    // Arithmetic, shift and rotate building blocks shared by the op select below
    always_comb begin
        sh          = b[SHW-1:0];
        sum         = a + b;
        diff        = a - b;
        a_ext       = DW'($signed(a));
        b_ext       = DW'($signed(b));
        prod        = a_ext * b_ext;
        quot        = $signed(a) / $signed(b);
        rem         = $signed(a) % $signed(b);
        div_by_zero = (b == '0);
        div_ovf     = (a == MOST_NEG) && (b == '1);
        // Rotates come from shifting a doubled copy of a: the wrapped bits
        // land in the half we keep, and a zero amount returns a unchanged.
        rot_src     = {a, a};
        rol_full    = rot_src << sh;
        ror_full    = rot_src >> sh;
    end

    // Operation select: next result, R15 update and flags
    always_comb begin
        res_d    = a;
        r15_d    = r15_q;
        r15_we_d = 1'b0;
        ovf_d    = 1'b0;
        unique case (ctrl)
            OP_ADD: begin
                res_d = sum;
                ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL: begin
                res_d    = prod[WIDTH-1:0];
                r15_d    = prod[DW-1:WIDTH];
                r15_we_d = 1'b1;
                // Fits in 16 signed bits only if the top half is a pure sign extension.
                ovf_d    = (prod[DW-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}});
            end
            OP_DIV: begin
                r15_we_d = 1'b1;
                if (div_by_zero) begin
                    res_d = '1;
                    r15_d = a;
                    ovf_d = 1'b1;
                end else if (div_ovf) begin
                    // -32768 / -1 cannot be represented; saturate to the dividend.
                    res_d = MOST_NEG;
                    r15_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    res_d = quot;
                    r15_d = rem;
                end
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_SLL: res_d = a << sh;
            OP_SRL: res_d = a >> sh;
            OP_SRA: res_d = $signed(a) >>> sh;
            OP_ROL: res_d = rol_full[DW-1:WIDTH];
            OP_ROR: res_d = ror_full[WIDTH-1:0];
            default: res_d = a;
        endcase
        zero_d = (res_d == '0);
    end

    // Output registers; asynchronous reset forces the idle result state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            r15_q    <= '0;
            r15_we_q <= 1'b0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            res_q    <= res_d;
            r15_q    <= r15_d;
            r15_we_q <= r15_we_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign res    = res_q;
    assign R15    = r15_q;
    assign r15_we = r15_we_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed-vector bench for alu16 with a cycle-by-cycle reference model.

module tb_alu16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic [15:0] R15;
    logic        r15_we;
    logic        zero;
    logic        ovf;

    alu16 #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .ctrl   (ctrl),
        .res    (res),
        .R15    (R15),
        .r15_we (r15_we),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] r15;
        logic        we;
        logic        zero;
        logic        ovf;
    } out_t;

    // Reference model: plain integer arithmetic on signed values.
    function automatic out_t model(input logic [15:0] fa, input logic [15:0] fb,
                                   input logic [3:0] op, input logic [15:0] prev_r15);
        out_t   o;
        int     sa;
        int     sb;
        int     ua;
        int     sh;
        int     r;
        int     q;
        int     rm;
        longint p;
        logic [15:0] t;
        sa = $signed(fa);
        sb = $signed(fb);
        ua = int'(fa);
        sh = int'(fb[3:0]);
        o.res = fa;
        o.r15 = prev_r15;
        o.we  = 1'b0;
        o.ovf = 1'b0;
        case (op)
            4'd0: begin r = sa + sb; o.res = r[15:0]; o.ovf = (r > 32767) || (r < -32768); end
            4'd1: begin r = sa - sb; o.res = r[15:0]; o.ovf = (r > 32767) || (r < -32768); end
            4'd2: begin
                p = longint'(sa) * longint'(sb);
                o.res = p[15:0];
                o.r15 = p[31:16];
                o.we  = 1'b1;
                o.ovf = (p > 32767) || (p < -32768);
            end
            4'd3: begin
                o.we = 1'b1;
                if (sb == 0) begin
                    o.res = 16'hFFFF; o.r15 = fa; o.ovf = 1'b1;
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    if (q > 32767) begin
                        o.res = 16'h8000; o.r15 = 16'h0000; o.ovf = 1'b1;
                    end else begin
                        o.res = q[15:0]; o.r15 = rm[15:0];
                    end
                end
            end
            4'd4: o.res = fa & fb;
            4'd5: o.res = fa | fb;
            4'd6: begin r = ua * (1 << sh); o.res = r[15:0]; end
            4'd7: begin r = ua / (1 << sh); o.res = r[15:0]; end
            4'd8: begin r = sa >>> sh; o.res = r[15:0]; end
            4'd9: begin
                t = fa;
                for (int i = 0; i < sh; i++) t = {t[14:0], t[15]};
                o.res = t;
            end
            4'd10: begin
                t = fa;
                for (int i = 0; i < sh; i++) t = {t[0], t[15:1]};
                o.res = t;
            end
            default: o.res = fa;
        endcase
        o.zero = (o.res == 16'h0000);
        return o;
    endfunction

    out_t exp_q;

    // Model state advances with the DUT clock and reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '{res: 16'h0000, r15: 16'h0000, we: 1'b0, zero: 1'b1, ovf: 1'b0};
        else        exp_q <= model(a, b, ctrl, exp_q.r15);
    end

    int n_vec;
    int n_miss;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    task automatic chk_lit(input string tag, input logic [15:0] e_res, input logic [15:0] e_r15,
                           input logic e_we, input logic e_zero, input logic e_ovf);
        chk({tag, ".res"}, res, e_res);
        chk({tag, ".R15"}, R15, e_r15);
        chk({tag, ".r15_we"}, 16'(r15_we), 16'(e_we));
        chk({tag, ".zero"}, 16'(zero), 16'(e_zero));
        chk({tag, ".ovf"}, 16'(ovf), 16'(e_ovf));
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] va;
        logic [15:0] vb;
        logic [15:0] e_res;
        logic [15:0] e_r15;
        logic        e_we;
        logic        e_zero;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[23];

    initial begin
        vecs[0]  = '{"add_0_1",     4'h0, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0};
        vecs[1]  = '{"add_ovf",     4'h0, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 0, 0, 1};
        vecs[2]  = '{"add_neg_ovf", 4'h0, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1};
        vecs[3]  = '{"sub_2_1",     4'h1, 16'h0002, 16'h0001, 16'h0001, 16'h0000, 0, 0, 0};
        vecs[4]  = '{"sub_zero",    4'h1, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 0, 1, 0};
        vecs[5]  = '{"sub_ovf",     4'h1, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 0, 0, 1};
        vecs[6]  = '{"mul_0",       4'h2, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 1, 1, 0};
        vecs[7]  = '{"mul_neg",     4'h2, 16'hFFFF, 16'h0002, 16'hFFFE, 16'hFFFF, 1, 0, 0};
        vecs[8]  = '{"mul_ovf",     4'h2, 16'h4000, 16'h0004, 16'h0000, 16'h0001, 1, 1, 1};
        vecs[9]  = '{"div_4_2",     4'h3, 16'h0004, 16'h0002, 16'h0002, 16'h0000, 1, 0, 0};
        vecs[10] = '{"div_4_3",     4'h3, 16'h0004, 16'h0003, 16'h0001, 16'h0001, 1, 0, 0};
        vecs[11] = '{"div_m7_2",    4'h3, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1, 0, 0};
        vecs[12] = '{"div_minneg",  4'h3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1, 0, 1};
        vecs[13] = '{"div_by_0",    4'h3, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1, 0, 1};
        vecs[14] = '{"and",         4'h4, 16'h8421, 16'h00FF, 16'h0021, 16'h1234, 0, 0, 0};
        vecs[15] = '{"or",          4'h5, 16'h8421, 16'h0004, 16'h8425, 16'h1234, 0, 0, 0};
        vecs[16] = '{"sll",         4'h6, 16'h8421, 16'h0004, 16'h4210, 16'h1234, 0, 0, 0};
        vecs[17] = '{"srl",         4'h7, 16'h8421, 16'h0004, 16'h0842, 16'h1234, 0, 0, 0};
        vecs[18] = '{"sra",         4'h8, 16'h8421, 16'h0004, 16'hF842, 16'h1234, 0, 0, 0};
        vecs[19] = '{"rol",         4'h9, 16'h8421, 16'h0004, 16'h4218, 16'h1234, 0, 0, 0};
        vecs[20] = '{"ror",         4'hA, 16'h8421, 16'h0004, 16'h1842, 16'h1234, 0, 0, 0};
        vecs[21] = '{"sll_amt0",    4'h6, 16'h8421, 16'hFFF0, 16'h8421, 16'h1234, 0, 0, 0};
        vecs[22] = '{"pass_zero",   4'hF, 16'h0000, 16'h1111, 16'h0000, 16'h1234, 0, 1, 0};
    end

    task automatic apply(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
        @(negedge clk);
        ctrl = op;
        a    = va;
        b    = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        a      = 16'h0000;
        b      = 16'h0000;
        ctrl   = 4'h0;

        // Cycle-accurate compare against the model on every falling edge.
        fork
            forever begin
                @(negedge clk);
                chk("cyc.res", res, exp_q.res);
                chk("cyc.R15", R15, exp_q.r15);
                chk("cyc.r15_we", 16'(r15_we), 16'(exp_q.we));
                chk("cyc.zero", 16'(zero), 16'(exp_q.zero));
                chk("cyc.ovf", 16'(ovf), 16'(exp_q.ovf));
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_lit("reset", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].va, vecs[i].vb);
            chk_lit(vecs[i].name, vecs[i].e_res, vecs[i].e_r15, vecs[i].e_we,
                    vecs[i].e_zero, vecs[i].e_ovf);
        end

        // Reset asserted mid-cycle while a MUL is set up: outputs clear at once.
        @(negedge clk);
        ctrl = 4'h2;
        a    = 16'hFFFF;
        b    = 16'h0002;
        #2;
        rst_n = 1'b0;
        #1;
        chk_lit("async_rst", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_lit("rst_hold", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_lit("rst_release", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_lit("first_capture", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Back-to-back pseudo-random operations checked by the model alone.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            ctrl = 4'($urandom_range(0, 15));
            a    = 16'($urandom);
            b    = (i % 7 == 0) ? 16'h0000 : 16'($urandom);
        end
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
